// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode/issue stage with operand forwarding, load-use stall,
// branch resolution and optional delay-slot squash.
module id_fwd_stage #(
   parameter int DATA_W     = 16,
   parameter int RADDR_W    = 4,
   parameter int NSRC       = 2,
   parameter int NFWD       = 3,
   parameter int CTL_W      = 8,
   parameter int DELAY_SLOT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_pc,
   input  logic [CTL_W-1:0]        in_ctl,
   input  logic                    in_we,
   input  logic [RADDR_W-1:0]      in_waddr,
   input  logic                    in_is_load,
   input  logic [NSRC-1:0]         src_re,
   input  logic [NSRC*RADDR_W-1:0] src_addr,
   input  logic [NSRC*DATA_W-1:0]  rf_data,
   input  logic [NSRC-1:0]         src_imm_sel,
   input  logic [DATA_W-1:0]       in_imm,
   input  logic [1:0]              br_type,
   input  logic [DATA_W-1:0]       br_off,
   input  logic [NFWD-1:0]         fwd_we,
   input  logic [NFWD*RADDR_W-1:0] fwd_addr,
   input  logic [NFWD*DATA_W-1:0]  fwd_data,
   input  logic [NFWD-1:0]         fwd_pending,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTL_W-1:0]        out_ctl,
   output logic [NSRC*DATA_W-1:0]  out_data,
   output logic                    out_we,
   output logic [RADDR_W-1:0]      out_waddr,
   output logic                    out_is_load,
   output logic                    branch_flag_o,
   output logic [DATA_W-1:0]       branch_addr_o,
   output logic                    stall_req,
   output logic [15:0]             stall_cnt
);
   typedef enum logic {RUN, SQUASH} state_t;
   state_t                   r_state, w_state_nxt;
   logic                     r_valid, r_we, r_is_load;
   logic [CTL_W-1:0]         r_ctl;
   logic [NSRC*DATA_W-1:0]   r_data;
   logic [RADDR_W-1:0]       r_waddr;
   logic [15:0]              r_cnt;
   logic [NSRC*DATA_W-1:0]   w_opnd;
   logic [NSRC-1:0]          w_pend;
   logic [DATA_W-1:0]        w_op0;
   logic                     w_hazard, w_adv, w_accept, w_taken;
   // Scan oldest to youngest so the youngest match (and its pending bit) wins.
   always_comb begin
      w_opnd = rf_data;
      w_pend = '0;
      for (int k = 0; k < NSRC; k++) begin
         for (int j = NFWD - 1; j >= 0; j--)
            if (src_re[k] && fwd_we[j] && fwd_addr[j*RADDR_W +: RADDR_W] == src_addr[k*RADDR_W +: RADDR_W]) begin
               w_opnd[k*DATA_W +: DATA_W] = fwd_data[j*DATA_W +: DATA_W];
               w_pend[k] = fwd_pending[j];
            end
         if (src_imm_sel[k]) begin
            w_opnd[k*DATA_W +: DATA_W] = in_imm;
            w_pend[k] = 1'b0;
         end
      end
   end
   assign w_hazard      = |w_pend;
   assign w_adv         = !r_valid || out_ready;
   assign in_ready      = !rst && !w_hazard && w_adv;
   assign w_accept      = in_valid && in_ready;
   assign w_op0         = w_opnd[DATA_W-1:0];
   assign w_taken       = w_accept && r_state == RUN &&
                          (br_type == 2'd1 || (br_type == 2'd2 && w_op0 == '0) || (br_type == 2'd3 && w_op0 != '0));
   assign branch_flag_o = w_taken;
   assign branch_addr_o = w_taken ? in_pc + br_off : '0;
   assign stall_req     = !rst && in_valid && (w_hazard || (r_valid && !out_ready));
   always_comb begin
      w_state_nxt = (r_state == RUN && w_taken && DELAY_SLOT == 0) ? SQUASH :
                    (r_state == SQUASH && w_accept) ? RUN : r_state;
   end
   always_ff @(posedge clk) begin
      r_state <= rst ? RUN : w_state_nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_we      <= 1'b0;
         r_is_load <= 1'b0;
         r_ctl     <= '0;
         r_data    <= '0;
         r_waddr   <= '0;
         r_cnt     <= '0;
      end else begin
         if (w_accept) begin
            r_valid   <= r_state == RUN;
            r_we      <= in_we && r_state == RUN;
            r_is_load <= in_is_load;
            r_ctl     <= in_ctl;
            r_data    <= w_opnd;
            r_waddr   <= in_waddr;
         end else if (w_adv) begin
            r_valid   <= 1'b0;
            r_we      <= 1'b0;
            r_is_load <= 1'b0;
         end
         if (stall_req && r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
      end
   end
   assign out_valid   = r_valid;
   assign out_we      = r_we;
   assign out_is_load = r_is_load;
   assign out_ctl     = r_ctl;
   assign out_data    = r_data;
   assign out_waddr   = r_waddr;
   assign stall_cnt   = r_cnt;
endmodule
